// File: rtl/delay_timer_arbiter_pkg.sv
// Shared definitions for the memory-game delay timer arbiter.
// Holds the FSM state encoding, the requester indices, the default tick
// divider, the prescaler counter width and a small pointer helper.
package delay_timer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned NUM_REQ          = 2;
  localparam int unsigned REQ_DISP         = 0;  // sequence-display LED on-time
  localparam int unsigned REQ_TMO          = 1;  // player-input timeout
  localparam int unsigned TICK_DIV_DEFAULT = 100;
  localparam int unsigned PRESC_W          = 7;

  // Round-robin pointer after serving requester w: prefer the other one.
  function automatic logic other_req(input logic w);
    return ~w;
  endfunction

endpackage

// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bus between the game FSM (master) and the delay timer
// arbiter (slave).
//   req   : per-requester request level, held until done is seen
//   dur0  : requester 0 duration in ticks
//   dur1  : requester 1 duration in ticks
//   gnt   : one-hot grant
//   done  : per-requester completion level
//   busy  : arbiter not idle
//   tick  : one-cycle prescaler pulse
interface delay_timer_arbiter_if #(
  parameter int unsigned DUR_W = 8
);

  logic [1:0]       req;
  logic [DUR_W-1:0] dur0;
  logic [DUR_W-1:0] dur1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic             tick;

  modport master (
    output req, dur0, dur1,
    input  gnt, done, busy, tick
  );

  modport slave (
    input  req, dur0, dur1,
    output gnt, done, busy, tick
  );

endinterface

// File: rtl/tick_prescaler.sv
// Interval prescaler: emits a registered one-cycle tick every TICK_DIV
// enabled cycles. clr has priority over en and restarts the interval.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   en   : count enable
//   clr  : synchronous clear of count and tick
//   tick : one-cycle pulse
module tick_prescaler
  import delay_timer_arbiter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = PRESC_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..TICK_DIV-1; the tick flop rises on the edge that wraps the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/delay_timer_arbiter.sv
// Shares one prescaled interval timer between the sequence-display
// requester (0) and the player-input timeout requester (1). Round-robin
// arbitration, duration latch, tick countdown and done handshake.
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : slave side of delay_timer_arbiter_if (req/dur0/dur1 in,
//         gnt/done/busy/tick out)
module delay_timer_arbiter
  import delay_timer_arbiter_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned DUR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  delay_timer_arbiter_if.slave  bus
);

  state_e               state;
  state_e               state_nxt;
  logic [DUR_W-1:0]     remaining;
  logic [DUR_W-1:0]     remaining_nxt;
  logic                 ptr;
  logic                 ptr_nxt;
  logic                 win;
  logic                 win_nxt;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   gnt_nxt;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   done_nxt;
  logic                 busy_q;
  logic                 win_sel;
  logic [DUR_W-1:0]     dur_sel;
  logic                 presc_clr;
  logic                 presc_en;
  logic                 tick;

  assign presc_en = (state == ST_RUN);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  // Next-state, arbitration and countdown.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    ptr_nxt       = ptr;
    win_nxt       = win;
    gnt_nxt       = gnt_q;
    done_nxt      = done_q;
    presc_clr     = 1'b0;
    win_sel       = ptr;
    dur_sel       = bus.dur0;

    // Both requesting: the pointer decides; otherwise the single requester.
    if (bus.req == 2'b11) begin
      win_sel = ptr;
    end else begin
      win_sel = bus.req[REQ_TMO];
    end
    dur_sel = (win_sel == 1'(REQ_TMO)) ? bus.dur1 : bus.dur0;

    unique case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          win_nxt          = win_sel;
          gnt_nxt          = '0;
          gnt_nxt[win_sel] = 1'b1;
          remaining_nxt    = dur_sel;
          presc_clr        = 1'b1;
          state_nxt        = (dur_sel == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // A dropped request aborts, even on the edge of the final tick.
        if (!bus.req[win]) begin
          gnt_nxt   = '0;
          done_nxt  = '0;
          ptr_nxt   = other_req(win);
          state_nxt = ST_IDLE;
        end else if (tick && (remaining != '0)) begin
          remaining_nxt = remaining - DUR_W'(1);
          if (remaining == DUR_W'(1)) begin
            done_nxt[win] = 1'b1;
            state_nxt     = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (!bus.req[win]) begin
          gnt_nxt   = '0;
          done_nxt  = '0;
          ptr_nxt   = other_req(win);
          state_nxt = ST_IDLE;
        end else begin
          // Zero-length jobs reach DONE one edge before done rises.
          done_nxt[win] = 1'b1;
        end
      end

      default: begin
        gnt_nxt   = '0;
        done_nxt  = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      ptr       <= 1'b0;
      win       <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      ptr       <= ptr_nxt;
      win       <= win_nxt;
      gnt_q     <= gnt_nxt;
      done_q    <= done_nxt;
      busy_q    <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Directed bench for delay_timer_arbiter with TICK_DIV=4, DUR_W=8.
module tb_delay_timer_arbiter;
  import delay_timer_arbiter_pkg::*;

  localparam int unsigned TD = 4;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  delay_timer_arbiter_if #(.DUR_W(DW)) bus ();

  delay_timer_arbiter #(
    .TICK_DIV (TD),
    .DUR_W    (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_done;
  int n_tick;
  int first_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for done[idx]; returns edges since the call, tick count
  // and the edge of the first tick. n=0 means done never came.
  task automatic wait_done(input int idx, input int max_cyc,
                           output int n, output int nt, output int ft);
    n  = 0;
    nt = 0;
    ft = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      step();
      if (bus.tick) begin
        nt++;
        if (ft == 0) ft = c;
      end
      if (bus.done[idx]) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst     = 1'b0;
    bus.req = 2'b00;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.dur0 = '0;
    bus.dur1 = '0;
    rst      = 1'b0;
    step();
    check("rst_gnt",  32'(bus.gnt),  32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_tick", 32'(bus.tick), 32'h0);
    rst = 1'b1;

    // 1: single requester 0, dur 3
    bus.dur0 = 8'd3;
    bus.req  = 2'b01;
    step();
    check("s1_gnt",  32'(bus.gnt),  32'h1);
    check("s1_busy", 32'(bus.busy), 32'h1);
    wait_done(0, 40, n_done, n_tick, first_tick);
    check("s1_done_lat",   32'(n_done),     32'd13);
    check("s1_ticks",      32'(n_tick),     32'd3);
    check("s1_first_tick", 32'(first_tick), 32'd4);
    check("s1_done",       32'(bus.done),   32'h1);
    check("s1_gnt_hold",   32'(bus.gnt),    32'h1);
    bus.req = 2'b00;
    step();
    check("s1_rel_gnt",  32'(bus.gnt),  32'h0);
    check("s1_rel_done", 32'(bus.done), 32'h0);
    check("s1_rel_busy", 32'(bus.busy), 32'h0);

    // 2: both requesting, round-robin alternation
    apply_reset();
    bus.dur0 = 8'd1;
    bus.dur1 = 8'd1;
    bus.req  = 2'b11;
    step();
    check("s2_gnt0", 32'(bus.gnt), 32'h1);
    wait_done(0, 20, n_done, n_tick, first_tick);
    check("s2_done0_lat", 32'(n_done), 32'd5);
    bus.req = 2'b10;
    step();
    check("s2_idle_gnt",  32'(bus.gnt),  32'h0);
    check("s2_idle_busy", 32'(bus.busy), 32'h0);
    bus.req = 2'b11;
    step();
    check("s2_gnt1", 32'(bus.gnt), 32'h2);
    wait_done(1, 20, n_done, n_tick, first_tick);
    check("s2_done1_lat", 32'(n_done),   32'd5);
    check("s2_done1",     32'(bus.done), 32'h2);
    bus.req = 2'b01;
    step();
    check("s2_idle2_gnt", 32'(bus.gnt), 32'h0);
    bus.req = 2'b11;
    step();
    check("s2_gnt0_again", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    step();
    check("s2_abort_gnt", 32'(bus.gnt), 32'h0);

    // 3: zero duration on requester 1
    bus.dur1 = 8'd0;
    bus.req  = 2'b10;
    step();
    check("s3_gnt",   32'(bus.gnt),  32'h2);
    check("s3_done0", 32'(bus.done), 32'h0);
    check("s3_tick0", 32'(bus.tick), 32'h0);
    step();
    check("s3_done",  32'(bus.done), 32'h2);
    check("s3_tick1", 32'(bus.tick), 32'h0);
    bus.req = 2'b00;
    step();
    check("s3_rel_done", 32'(bus.done), 32'h0);

    // 4: abort of requester 0 mid-run, pending requester 1 then served
    bus.dur0 = 8'd5;
    bus.dur1 = 8'd1;
    bus.req  = 2'b01;
    step();
    check("s4_gnt", 32'(bus.gnt), 32'h1);
    repeat (9) step();
    bus.req = 2'b10;
    step();
    check("s4_abort_gnt",  32'(bus.gnt),  32'h0);
    check("s4_abort_done", 32'(bus.done), 32'h0);
    check("s4_abort_busy", 32'(bus.busy), 32'h0);
    step();
    check("s4_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 2'b00;
    step();
    check("s4_rel_gnt", 32'(bus.gnt), 32'h0);

    // Abort on the edge of the final tick: abort wins
    bus.dur0 = 8'd1;
    bus.req  = 2'b01;
    step();
    repeat (4) step();
    check("fin_tick", 32'(bus.tick), 32'h1);
    bus.req = 2'b00;
    step();
    check("fin_done", 32'(bus.done), 32'h0);
    check("fin_gnt",  32'(bus.gnt),  32'h0);
    check("fin_busy", 32'(bus.busy), 32'h0);

    // 5: asynchronous reset mid-run, then fresh job
    bus.dur0 = 8'd5;
    bus.req  = 2'b01;
    step();
    repeat (6) step();
    check("s5_pre_busy", 32'(bus.busy), 32'h1);
    #1 rst = 1'b0;
    #1;
    check("s5_rst_gnt",  32'(bus.gnt),  32'h0);
    check("s5_rst_done", 32'(bus.done), 32'h0);
    check("s5_rst_busy", 32'(bus.busy), 32'h0);
    check("s5_rst_tick", 32'(bus.tick), 32'h0);
    bus.req = 2'b00;
    step();
    step();
    rst      = 1'b1;
    bus.dur0 = 8'd2;
    bus.req  = 2'b01;
    step();
    check("s5_gnt", 32'(bus.gnt), 32'h1);
    wait_done(0, 30, n_done, n_tick, first_tick);
    check("s5_done_lat", 32'(n_done), 32'd9);
    check("s5_ticks",    32'(n_tick), 32'd2);
    bus.req = 2'b00;
    step();

    // 6: duration change during RUN is ignored
    bus.dur0 = 8'd2;
    bus.req  = 2'b01;
    step();
    bus.dur0 = 8'd9;
    wait_done(0, 60, n_done, n_tick, first_tick);
    check("s6_done_lat", 32'(n_done), 32'd9);
    bus.req = 2'b00;
    step();
    check("s6_rel_gnt", 32'(bus.gnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
